stream_arbiter_rr: RTL and testbench
====================================

Name: stream_arbiter_rr

Overview:
- Parametrised N-port AXI-Stream packet arbiter merging game-event streams (UART input, timers, enemy AI, ...) into one stream for the game-logic core.
- Generalises the two-port fixed-priority merger in four ways:
  - configurable data width and port count;
  - selectable fixed-priority or round-robin mode;
  - packet locking on tlast;
  - a registered output stage that honours downstream backpressure without dropping or duplicating beats.

Parameters:
- DATA_W, 64: tdata width per port, in bits.
- NUM_PORTS, 4: number of input ports, 2..16.
- RR_MODE, 1: 0 = fixed priority (lowest index wins); 1 = round-robin.
- ID_W, $clog2(NUM_PORTS): width of the source-id output. Derived; do not override.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- s_axis_tdata  in  NUM_PORTS*DATA_W  port i occupies bits [i*DATA_W +: DATA_W].
- s_axis_tvalid  in  NUM_PORTS  per-port valid.
- s_axis_tlast  in  NUM_PORTS  per-port end-of-packet.
- s_axis_tready  out  NUM_PORTS  per-port ready.
- m_axis_tdata  out  DATA_W  merged data (registered).
- m_axis_tvalid  out  1  merged valid (registered).
- m_axis_tlast  out  1  merged last (registered).
- m_axis_tid  out  ID_W  index of the source port of the current output beat (registered).
- m_axis_tready  in  1  downstream ready.
- busy  out  1  high while a multi-beat packet is locked.

Behaviour:
- Reset (async assert, sync release):
  - m_axis_tvalid = 0, m_axis_tdata = 0, m_axis_tlast = 0, m_axis_tid = 0.
  - locked = 0, busy = 0, rr_ptr = 0.
  - s_axis_tready is all 0 while rst is high.
- Output slot:
  - One register stage. space = !m_axis_tvalid | m_axis_tready (combinational).
  - Downstream handshake completes on m_axis_tvalid & m_axis_tready.
- Grant selection, combinational, when unlocked:
  - RR_MODE = 0: lowest-index port with tvalid = 1.
  - RR_MODE = 1: first valid port scanning upward from rr_ptr, wrapping NUM_PORTS-1 -> 0.
  - No port valid: no grant, all tready = 0.
- Grant when locked: always lock_port. Valid on other ports is ignored.
- Ready:
  - s_axis_tready[g] = space for the granted port g.
  - Every other port sees tready = 0.
  - tready never depends on that port's own tvalid.
- Transfer on s_axis_tvalid[g] & s_axis_tready[g]:
  - Next edge loads m_axis_tdata, tlast, tid = g and sets m_axis_tvalid = 1.
  - Latency: exactly 1 cycle input to output. Throughput: 1 beat/cycle when m_axis_tready stays high.
- If space = 1 and no transfer occurs, m_axis_tvalid clears to 0 on the next edge.
- If space = 0, output registers hold. tdata, tlast and tid must stay stable while tvalid = 1 and tready = 0.
- Packet lock:
  - A transfer with tlast = 0 while unlocked sets locked = 1 and lock_port = g.
  - A transfer from lock_port with tlast = 1 clears locked.
  - Single-beat packets (tlast = 1 on the first beat) never lock.
  - busy = locked.
- Round-robin pointer: updated only when a tlast = 1 beat is accepted from port g; rr_ptr <= (g == NUM_PORTS-1) ? 0 : g+1. Unchanged in fixed mode.
- Simultaneous events:
  - A new grant may take effect in the same cycle the previous packet's tlast is accepted. The arbitration for the cycle after that acceptance uses the updated rr_ptr.
  - Back-to-back packets from different ports with no bubble are required.
- Starvation: in RR mode every continuously valid port is granted within NUM_PORTS packets. Fixed mode may starve high indices; this is by design.
- Reset mid-packet:
  - Lock and output are discarded. No partial-packet recovery.
  - Upstream sources must also be reset.

Test Plan:
- RR_MODE = 1, NUM_PORTS = 4, all ports continuously sending single-beat packets with tdata = port index, m_axis_tready = 1 -> output tid sequence 0,1,2,3,0,1,...; first valid output appears one cycle after the first accept; no bubbles.
- Port 2 sends a 3-beat packet (0xA0, 0xA1, 0xA2 with tlast on the last beat) while port 0 is valid throughout -> port 0 tready = 0 and busy = 1 for the whole packet; output is A0, A1, A2 contiguous with tid = 2; port 0's beat follows on the next cycle.
- Backpressure: m_axis_tready toggles 1,0,0,1 during a 4-beat packet -> no beat lost or duplicated; m_axis_tdata stable while stalled; source tready = 0 exactly on the cycles where space = 0.
- RR_MODE = 0: ports 1 and 3 are both always valid with single-beat packets -> only tid = 1 ever appears; port 3 tready stays 0.
- Assert rst mid-packet (locked, m_axis_tvalid = 1) -> next sample shows m_axis_tvalid = 0, busy = 0, tid = 0, all tready = 0; after release, arbitration restarts from port 0.
- rr_ptr wrap: port 3's last beat is accepted with only ports 0 and 3 valid -> next grant goes to port 0.

Source files
------------

// File: rtl/stream_arbiter_rr.sv
// stream_arbiter_rr: N-port AXI-Stream packet arbiter (fixed priority or round-robin) with packet locking and a registered output
//   clk, rst                    clock, asynchronous active-high reset
//   s_axis_tdata/tvalid/tlast   NUM_PORTS input streams, port i in tdata[i*DATA_W +: DATA_W]
//   s_axis_tready               per-port ready, only the granted port may see it high
//   m_axis_tdata/tvalid/tlast   merged registered output stream
//   m_axis_tid                  source port index of the current output beat
//   m_axis_tready               downstream ready
//   busy                        high while a multi-beat packet holds the grant
module stream_arbiter_rr #(
    parameter int DATA_W    = 64,
    parameter int NUM_PORTS = 4,
    parameter int RR_MODE   = 1,
    parameter int ID_W      = $clog2(NUM_PORTS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_PORTS*DATA_W-1:0]   s_axis_tdata,
    input  logic [NUM_PORTS-1:0]          s_axis_tvalid,
    input  logic [NUM_PORTS-1:0]          s_axis_tlast,
    output logic [NUM_PORTS-1:0]          s_axis_tready,
    output logic [DATA_W-1:0]             m_axis_tdata,
    output logic                          m_axis_tvalid,
    output logic                          m_axis_tlast,
    output logic [ID_W-1:0]               m_axis_tid,
    input  logic                          m_axis_tready,
    output logic                          busy
);
    logic              valid_q, valid_d, last_q, last_d, locked_q, locked_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [ID_W-1:0]   tid_q, tid_d, lock_port_q, lock_port_d, rr_ptr_q, rr_ptr_d;
    logic              space, gnt_vld, xfer, in_last;
    logic [ID_W-1:0]   gnt;
    logic [DATA_W-1:0] in_data;
    int                idx;

    // Scan from the highest offset downwards so the last hit is the closest port to the scan origin.
    always_comb begin
        gnt_vld = 1'b0;
        gnt     = '0;
        idx     = 0;
        if (locked_q) begin
            gnt_vld = 1'b1;
            gnt     = lock_port_q;
        end else begin
            for (int k = NUM_PORTS - 1; k >= 0; k--) begin
                idx = (RR_MODE != 0) ? (int'(rr_ptr_q) + k) % NUM_PORTS : k;
                if (s_axis_tvalid[idx]) begin
                    gnt_vld = 1'b1;
                    gnt     = ID_W'(idx);
                end
            end
        end
    end

    assign space         = !valid_q || m_axis_tready;
    assign in_data       = s_axis_tdata[gnt*DATA_W +: DATA_W];
    assign in_last       = s_axis_tlast[gnt];
    assign xfer          = gnt_vld && space && s_axis_tvalid[gnt];
    assign s_axis_tready = (gnt_vld && !rst) ? NUM_PORTS'(space) << gnt : '0;

    always_comb begin
        valid_d     = space ? xfer : valid_q;
        data_d      = xfer ? in_data : data_q;
        last_d      = xfer ? in_last : last_q;
        tid_d       = xfer ? gnt : tid_q;
        locked_d    = xfer ? !in_last : locked_q;
        lock_port_d = (xfer && !locked_q) ? gnt : lock_port_q;
        rr_ptr_d    = (RR_MODE != 0 && xfer && in_last) ?
                      ((gnt == ID_W'(NUM_PORTS - 1)) ? '0 : gnt + 1'b1) : rr_ptr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q     <= 1'b0;
            data_q      <= '0;
            last_q      <= 1'b0;
            tid_q       <= '0;
            locked_q    <= 1'b0;
            lock_port_q <= '0;
            rr_ptr_q    <= '0;
        end else begin
            valid_q     <= valid_d;
            data_q      <= data_d;
            last_q      <= last_d;
            tid_q       <= tid_d;
            locked_q    <= locked_d;
            lock_port_q <= lock_port_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign m_axis_tdata  = data_q;
    assign m_axis_tvalid = valid_q;
    assign m_axis_tlast  = last_q;
    assign m_axis_tid    = tid_q;
    assign busy          = locked_q;
endmodule

// File: tb/tb_stream_arbiter_rr.sv
// tb_stream_arbiter_rr: directed self-checking bench for stream_arbiter_rr in round-robin and fixed-priority modes
module tb_stream_arbiter_rr;
    localparam int DW = 64;
    localparam int NP = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NP*DW-1:0] s_tdata = '0;
    logic [NP-1:0]   s_tvalid = '0, s_tlast = '0, s_tready;
    logic [DW-1:0]   m_tdata;
    logic            m_tvalid, m_tlast, m_tready = 1'b1, busy;
    logic [1:0]      m_tid;

    logic [NP*DW-1:0] f_tdata = '0;
    logic [NP-1:0]   f_tvalid = 4'b1010, f_tlast = 4'b1111, f_tready;
    logic [DW-1:0]   f_mdata;
    logic            f_mvalid, f_mlast, f_busy;
    logic [1:0]      f_tid;

    int n_tests = 0;
    int n_fail = 0;

    logic [3:0]  t3_r    [8] = '{1, 0, 0, 1, 1, 1, 1, 1};
    logic [3:0]  t3_v    [8] = '{1, 1, 1, 1, 1, 1, 0, 0};
    logic [63:0] t3_d    [8] = '{'hB0, 'hB1, 'hB1, 'hB1, 'hB2, 'hB3, 0, 0};
    logic [3:0]  t3_l    [8] = '{0, 0, 0, 0, 0, 1, 0, 0};
    logic [3:0]  t3_etr  [8] = '{4'b0010, 0, 0, 4'b0010, 4'b0010, 4'b0010, 0, 0};
    logic [3:0]  t3_ev   [8] = '{0, 1, 1, 1, 1, 1, 1, 0};
    logic [63:0] t3_ed   [8] = '{0, 'hB0, 'hB0, 'hB0, 'hB1, 'hB2, 'hB3, 0};
    logic [3:0]  t3_eb   [8] = '{0, 1, 1, 1, 1, 1, 0, 0};

    stream_arbiter_rr #(.DATA_W(DW), .NUM_PORTS(NP), .RR_MODE(1)) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast), .m_axis_tid(m_tid),
        .m_axis_tready(m_tready), .busy(busy)
    );

    stream_arbiter_rr #(.DATA_W(DW), .NUM_PORTS(NP), .RR_MODE(0)) dut_fp (
        .clk(clk), .rst(rst),
        .s_axis_tdata(f_tdata), .s_axis_tvalid(f_tvalid), .s_axis_tlast(f_tlast), .s_axis_tready(f_tready),
        .m_axis_tdata(f_mdata), .m_axis_tvalid(f_mvalid), .m_axis_tlast(f_mlast), .m_axis_tid(f_tid),
        .m_axis_tready(1'b1), .busy(f_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < NP; i++) f_tdata[i*DW +: DW] = DW'(i);
        #2;
        chk("rst_valid", m_tvalid, 0);
        chk("rst_data", m_tdata, 0);
        chk("rst_tid", m_tid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", s_tready, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // round-robin over four single-beat sources
        for (int i = 0; i < NP; i++) s_tdata[i*DW +: DW] = DW'(i);
        s_tlast  = 4'b1111;
        s_tvalid = 4'b1111;
        #1;
        chk("rr_first_ready", s_tready, 4'b0001);
        chk("rr_first_valid", m_tvalid, 0);
        for (int i = 0; i < 8; i++) begin
            cyc();
            chk("rr_valid", m_tvalid, 1);
            chk("rr_tid", m_tid, i % 4);
            chk("rr_data", m_tdata, i % 4);
            chk("rr_ready", s_tready, 4'b0001 << ((i + 1) % 4));
        end
        s_tvalid = '0;
        cyc();
        chk("rr_drain", m_tvalid, 0);

        // port 2 locks a 3-beat packet while port 0 waits
        s_tdata[2*DW +: DW] = 'hA0;
        s_tlast  = 4'b0000;
        s_tvalid = 4'b0100;
        #1;
        chk("lk_ready0", s_tready, 4'b0100);
        cyc();
        s_tdata[0 +: DW]    = 'h55;
        s_tlast[0]          = 1'b1;
        s_tvalid[0]         = 1'b1;
        s_tdata[2*DW +: DW] = 'hA1;
        #1;
        chk("lk_busy1", busy, 1);
        chk("lk_ready1", s_tready, 4'b0100);
        chk("lk_data1", m_tdata, 'hA0);
        chk("lk_tid1", m_tid, 2);
        chk("lk_last1", m_tlast, 0);
        cyc();
        s_tdata[2*DW +: DW] = 'hA2;
        s_tlast[2]          = 1'b1;
        #1;
        chk("lk_busy2", busy, 1);
        chk("lk_ready2", s_tready, 4'b0100);
        chk("lk_data2", m_tdata, 'hA1);
        cyc();
        s_tvalid[2] = 1'b0;
        #1;
        chk("lk_busy3", busy, 0);
        chk("lk_ready3", s_tready, 4'b0001);
        chk("lk_data3", m_tdata, 'hA2);
        chk("lk_tid3", m_tid, 2);
        chk("lk_last3", m_tlast, 1);
        cyc();
        s_tvalid = '0;
        chk("lk_p0_valid", m_tvalid, 1);
        chk("lk_p0_data", m_tdata, 'h55);
        chk("lk_p0_tid", m_tid, 0);
        cyc();
        chk("lk_drain", m_tvalid, 0);

        // backpressure during a 4-beat packet from port 1
        for (int t = 0; t < 8; t++) begin
            cyc();
            m_tready            = t3_r[t][0];
            s_tvalid            = {2'b00, t3_v[t][0], 1'b0};
            s_tdata[1*DW +: DW] = t3_d[t];
            s_tlast             = {2'b00, t3_l[t][0], 1'b0};
            #1;
            chk("bp_ready", s_tready, t3_etr[t]);
            chk("bp_valid", m_tvalid, t3_ev[t]);
            chk("bp_busy", busy, t3_eb[t]);
            if (t3_ev[t][0]) begin
                chk("bp_data", m_tdata, t3_ed[t]);
                chk("bp_tid", m_tid, 1);
            end
        end

        // reset in the middle of a locked packet from port 3
        cyc();
        s_tdata[3*DW +: DW] = 'hC0;
        s_tlast  = 4'b0000;
        s_tvalid = 4'b1000;
        #1;
        chk("mr_ready", s_tready, 4'b1000);
        cyc();
        chk("mr_busy_pre", busy, 1);
        chk("mr_valid_pre", m_tvalid, 1);
        chk("mr_tid_pre", m_tid, 3);
        rst = 1'b1;
        #1;
        chk("mr_valid", m_tvalid, 0);
        chk("mr_busy", busy, 0);
        chk("mr_tid", m_tid, 0);
        chk("mr_ready_rst", s_tready, 0);
        for (int i = 0; i < NP; i++) s_tdata[i*DW +: DW] = DW'(i);
        s_tlast  = 4'b1111;
        s_tvalid = 4'b1111;
        #1;
        chk("mr_ready_rst_v", s_tready, 0);
        cyc();
        rst = 1'b0;
        #1;
        chk("mr_restart", s_tready, 4'b0001);

        // pointer wrap from port 3 back to port 0
        cyc();
        s_tvalid = 4'b1001;
        #1;
        chk("wr_ready3", s_tready, 4'b1000);
        chk("wr_tid0", m_tid, 0);
        cyc();
        chk("wr_ready0", s_tready, 4'b0001);
        chk("wr_tid3", m_tid, 3);
        s_tvalid = '0;

        // fixed priority starves port 3
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("fp_ready", f_tready, 4'b0010);
            chk("fp_valid", f_mvalid, 1);
            chk("fp_tid", f_tid, 1);
            chk("fp_data", f_mdata, 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
